// File: rtl/hdb3_dcsch.sv
// rtl/hdb3_dcsch.sv - time-shared HDB3 decode scheduler, round-robin over N channel contexts
// Optional overrun flags enabled by defining HDB3SCH_OVR_EN.

module hdb3_dcsch #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  chan_en,
    input  logic [N-1:0]  in_vld,
    input  logic [N-1:0]  in_pos,
    input  logic [N-1:0]  in_neg,
    output logic          out_vld,
    output logic [CW-1:0] out_ch,
    output logic          out_nrz,
    output logic [N-1:0]  ovr,
    input  logic [N-1:0]  ovr_clr
);

    logic [N-1:0]  pend_q, pend_d, p_q, p_d, n_q, n_d, ovr_q, ovr_d;
    logic [N-1:0]  vlt_q, vlt_d, force_q, force_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [4:0]    sh_q   [N];
    logic [4:0]    sh_d   [N];
    logic [1:0]    lp1_q  [N];
    logic [1:0]    lp1_d  [N];
    logic [1:0]    lp2_q  [N];
    logic [1:0]    lp2_d  [N];
    logic [1:0]    zcnt_q [N];
    logic [1:0]    zcnt_d [N];
    logic          out_vld_q, out_vld_d, out_nrz_q, out_nrz_d;
    logic [CW-1:0] out_ch_q, out_ch_d;
    logic          gnt_vld;
    logic [CW-1:0] gnt_idx;

    // First pending, enabled channel at or after ptr, wrapping modulo N.
    always_comb begin : arb
        logic [CW:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (CW+1)'(i);
            if (cand >= (CW+1)'(N)) cand = cand - (CW+1)'(N);
            if (!gnt_vld && pend_q[cand[CW-1:0]] && chan_en[cand[CW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[CW-1:0];
            end
        end
    end

    always_comb begin : dec
        logic g_p, g_n, zp;
        pend_d    = pend_q;
        p_d       = p_q;
        n_d       = n_q;
        vlt_d     = vlt_q;
        force_d   = force_q;
        sh_d      = sh_q;
        lp1_d     = lp1_q;
        lp2_d     = lp2_q;
        zcnt_d    = zcnt_q;
        ptr_d     = ptr_q;
        ovr_d     = '0;
        out_vld_d = gnt_vld;
        out_ch_d  = gnt_vld ? gnt_idx : '0;
        out_nrz_d = 1'b0;
        g_p       = p_q[gnt_idx];
        g_n       = n_q[gnt_idx];
        zp        = sh_q[gnt_idx][0] & ~sh_q[gnt_idx][1] & ~sh_q[gnt_idx][2];

        if (gnt_vld) begin
            ptr_d          = (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + CW'(1);
            out_nrz_d      = sh_q[gnt_idx][4] & force_q[gnt_idx];
            sh_d[gnt_idx]  = {sh_q[gnt_idx][3:0], g_p ^ g_n};
            case ({g_p, g_n})
                2'b10:   lp1_d[gnt_idx] = 2'b10;
                2'b01:   lp1_d[gnt_idx] = 2'b01;
                2'b11:   lp1_d[gnt_idx] = 2'b00;
                default: lp1_d[gnt_idx] = lp1_q[gnt_idx];
            endcase
            lp2_d[gnt_idx] = lp1_q[gnt_idx];
            vlt_d[gnt_idx] = (g_p & lp2_q[gnt_idx][1]) | (g_n & lp2_q[gnt_idx][0]);
            // A zero-preceded violation opens a suppression window over the next four bits.
            if (zp && vlt_q[gnt_idx]) begin
                zcnt_d[gnt_idx]  = 2'd3;
                force_d[gnt_idx] = 1'b0;
            end else if (zcnt_q[gnt_idx] != 2'd0) begin
                zcnt_d[gnt_idx]  = zcnt_q[gnt_idx] - 2'd1;
                force_d[gnt_idx] = 1'b0;
            end else begin
                force_d[gnt_idx] = 1'b1;
            end
        end

        for (int i = 0; i < N; i++) begin
            if (!chan_en[i]) begin
                pend_d[i]  = 1'b0;
                sh_d[i]    = '0;
                lp1_d[i]   = '0;
                lp2_d[i]   = '0;
                vlt_d[i]   = 1'b0;
                zcnt_d[i]  = '0;
                force_d[i] = 1'b1;
            end else if (in_vld[i]) begin
                p_d[i]    = in_pos[i];
                n_d[i]    = in_neg[i];
                pend_d[i] = 1'b1;
            end else if (gnt_vld && gnt_idx == CW'(i)) begin
                pend_d[i] = 1'b0;
            end
`ifdef HDB3SCH_OVR_EN
            ovr_d[i] = (chan_en[i] & in_vld[i] & pend_q[i] & ~(gnt_vld && gnt_idx == CW'(i)))
                     | (ovr_q[i] & ~ovr_clr[i]);
`endif
        end
    end

`ifndef HDB3SCH_OVR_EN
    logic unused_ovr_clr;
    assign unused_ovr_clr = ^ovr_clr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            p_q       <= '0;
            n_q       <= '0;
            vlt_q     <= '0;
            force_q   <= '1;
            ptr_q     <= '0;
            ovr_q     <= '0;
            out_vld_q <= 1'b0;
            out_ch_q  <= '0;
            out_nrz_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                sh_q[i]   <= '0;
                lp1_q[i]  <= '0;
                lp2_q[i]  <= '0;
                zcnt_q[i] <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            p_q       <= p_d;
            n_q       <= n_d;
            vlt_q     <= vlt_d;
            force_q   <= force_d;
            ptr_q     <= ptr_d;
            ovr_q     <= ovr_d;
            out_vld_q <= out_vld_d;
            out_ch_q  <= out_ch_d;
            out_nrz_q <= out_nrz_d;
            sh_q      <= sh_d;
            lp1_q     <= lp1_d;
            lp2_q     <= lp2_d;
            zcnt_q    <= zcnt_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_ch  = out_ch_q;
    assign out_nrz = out_nrz_q;
    assign ovr     = ovr_q;

endmodule

// File: doc/hdb3_dcsch.md
# hdb3_dcsch

Time-shared HDB3 decode scheduler for the E1 tributary receive side. Accepts one bipolar symbol ({pos,neg}) per channel from up to N LIU interfaces, and arbitrates them round-robin onto a single decode engine. Per-channel decoder state lives in a context register file. Emits one NRZ bit per serviced symbol, tagged with its channel number, toward the E1 framers.

## Interface
- N, 4, number of tributary channels (2..32)
- CW, 2, channel-id width; N ≤ 2^CW
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- chan_en  in  N  per-channel enable
- in_vld  in  N  per-channel symbol strobe
- in_pos  in  N  positive rail, sampled when in_vld[i]=1
- in_neg  in  N  negative rail, sampled when in_vld[i]=1
- out_vld  out  1  decoded bit valid (registered)
- out_ch  out  CW  channel of decoded bit
- out_nrz  out  1  decoded NRZ bit
- ovr  out  N  sticky overrun flags
- ovr_clr  in  N  clears ovr[i]

## Operation
- Capture: per channel, 1-entry buffer {pend, p, n}. in_vld[i]=1 and chan_en[i]=1 → p,n ← in_pos/in_neg and pend ← 1 at the clock edge.
- Arbiter: grant = lowest index ≥ ptr, wrapping, with pend=1 and chan_en=1. On grant, ptr ← grant+1 mod N and pend[grant] ← 0. At most one grant per cycle.
- Simultaneous in_vld and grant on the same channel: the grant consumes the old symbol; the new symbol is written and pend stays 1; no overrun.
- Overrun: in_vld[i] while pend[i]=1 and channel i is not granted → new symbol overwrites, ovr[i] ← 1. ovr_clr[i] clears ovr[i]; a set and a clear in the same cycle → set wins.
- Context per channel: sh[4:0], lp1[1:0], lp2[1:0], vlt, zcnt[1:0], force. Reset/disabled value: all 0, force=1.
- Decode step for the granted channel, all from current context and s = p^n:
  - out_nrz = sh[4] & force
  - sh ← {sh[3:0], s}
  - lp1 ← 10 if {p,n}=10, 01 if 01, hold if 00, 00 if 11
  - lp2 ← lp1
  - vlt ← (p & lp2[1]) | (n & lp2[0])
  - zp = sh[0] & !sh[1] & !sh[2]
  - if zp & vlt: zcnt ← 3, force ← 0
  - else if zcnt≠0: zcnt ← zcnt−1, force ← 0
  - else force ← 1
- Context write-back occurs at the same edge as out_vld. A channel granted in back-to-back cycles sees the updated context.
- chan_en[i]=0: captures ignored, pend[i] cleared, context forced to reset values; ovr[i] held.

## Timing
- in_vld at cycle t → earliest grant in t+1 → out_vld/out_ch/out_nrz valid in t+2 for exactly 1 cycle.
- Sustained throughput: 1 symbol/cycle aggregate. Each channel is guaranteed service within N cycles of pend.
- A bit enters the datapath and emerges 5 decode steps later on its own channel, independent of wall-clock cycles.
- Reset, including mid-operation: pend=0, ptr=0, contexts reset, ovr=0, out_vld=0, out_ch=0, out_nrz=0 on the cycle after rst is sampled.

## Configuration
- HDB3SCH_OVR_EN defined: overrun detection, ovr and ovr_clr behave as above.
- HDB3SCH_OVR_EN undefined: ovr tied to 0, ovr_clr ignored; overwrite-on-pending behaviour is unchanged.

## Test plan
- Channel 2 only, symbols +,0,0,0,+ then 0s → out_nrz on ch2 for steps 1..10 = 0,0,0,0,0,1,0,0,0,0 (V suppressed, force low steps 7–10).
- Channel 2, symbols +,0,0,0,− then 0s → steps 1..10 = 0,0,0,0,0,1,0,0,0,1 (no violation, no suppression).
- All 4 channels in_vld same cycle → grants 0,1,2,3 on consecutive cycles; out_ch 0,1,2,3 in t+2..t+5.
- Channel 1 in_vld on two consecutive cycles while ch0 and ch1 are pending and ptr=0 → ovr[1]=1. The second symbol is decoded, the first is lost. ovr_clr[1] → 0 next cycle.
- rst asserted mid-stream with pend set on channels 0 and 3 → no out_vld afterward. The next decode on each channel uses reset context, so its first 5 steps output 0.
- chan_en[1] dropped mid-stream and restored → channel 1 restarts from reset context. Other channels are unaffected.
